// File: rtl/mealy_1011.sv
// Mealy detector for the serial pattern 1-0-1-1; zout is combinational from state and xin.
// Define MEALY_1011_COUNT_EN to add the match_count output and its wrapping counter.
module mealy_1011 #(
    parameter int unsigned OVERLAP = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             xin,
    output logic             zout
`ifdef MEALY_1011_COUNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;

    state_t state_q, state_d;

    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("mealy_1011: CNT_W must be at least 1");
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // zout is gated by rst so it stays 0 during reset even when xin is unknown.
    always_comb begin
        state_d = S0;
        zout    = 1'b0;
        case (state_q)
            S0: state_d = xin ? S1 : S0;
            S1: state_d = xin ? S1 : S2;
            S2: state_d = xin ? S3 : S0;
            S3: begin
                if (xin) begin
                    state_d = (OVERLAP != 0) ? S1 : S0;
                    zout    = rst;
                end else begin
                    state_d = S2;
                end
            end
            default: begin
                state_d = S0;
                zout    = 1'b0;
            end
        endcase
    end

`ifdef MEALY_1011_COUNT_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (zout) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count = count_q;
`endif

endmodule

// File: tb/tb_mealy_1011.sv
// Table-driven bench for mealy_1011: one overlapping and one non-overlapping instance share
// clk, rst and xin; hand-written sequences cover reset, Mealy timing and mid-pattern reset.
module tb_mealy_1011;

    logic clk;
    logic rst;
    logic xin;
    logic zout_ov;
    logic zout_no;
`ifdef MEALY_1011_COUNT_EN
    logic [7:0] cnt_ov;
    logic [7:0] cnt_no;
`endif

    int n_cmp;
    int n_bad;
    int exp_cnt_ov;
    int exp_cnt_no;

    mealy_1011 #(.OVERLAP(1), .CNT_W(8)) u_ov (
        .clk         (clk),
        .rst         (rst),
        .xin         (xin),
        .zout        (zout_ov)
`ifdef MEALY_1011_COUNT_EN
        ,
        .match_count (cnt_ov)
`endif
    );

    mealy_1011 #(.OVERLAP(0), .CNT_W(8)) u_no (
        .clk         (clk),
        .rst         (rst),
        .xin         (xin),
        .zout        (zout_no)
`ifdef MEALY_1011_COUNT_EN
        ,
        .match_count (cnt_no)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit rst_before;
        bit x;
        bit z_ov;
        bit z_no;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic check_counts(input int idx);
`ifdef MEALY_1011_COUNT_EN
        check("count_ov", idx, 32'(cnt_ov), 32'(exp_cnt_ov[7:0]));
        check("count_no", idx, 32'(cnt_no), 32'(exp_cnt_no[7:0]));
`endif
    endtask

    // Reset with xin unknown; zout must stay low before and after a clock edge in reset.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        xin = 1'bx;
        #1;
        check("rst_z_ov", 0, 32'(zout_ov), 32'd0);
        check("rst_z_no", 0, 32'(zout_no), 32'd0);
        @(posedge clk);
        #1;
        check("rst_z_ov", 1, 32'(zout_ov), 32'd0);
        check("rst_z_no", 1, 32'(zout_no), 32'd0);
        exp_cnt_ov = 0;
        exp_cnt_no = 0;
        check_counts(100);
        @(negedge clk);
        rst = 1'b1;
        xin = 1'b0;
    endtask

    task automatic step(input logic x, input logic e_ov, input logic e_no, input int idx);
        @(negedge clk);
        xin = x;
        #1;
        check("z_ov", idx, 32'(zout_ov), 32'(e_ov));
        check("z_no", idx, 32'(zout_no), 32'(e_no));
        @(posedge clk);
        #1;
        if (e_ov) exp_cnt_ov++;
        if (e_no) exp_cnt_no++;
        check_counts(idx);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        exp_cnt_ov = 0;
        exp_cnt_no = 0;
        rst        = 1'b0;
        xin        = 1'bx;

        // stream 1,1,0,1,1,0,0,1,0,1,1,0 : matches on bits 5 and 11 in both modes
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0};
        // stream 1,0,1,1,0,1,1 : overlap matches on bits 4 and 7, non-overlap on bit 4 only
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0};

        #1;
        check("init_z_ov", 0, 32'(zout_ov), 32'd0);
        check("init_z_no", 0, 32'(zout_no), 32'd0);

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rst_before) do_reset();
            step(tbl[i].x, tbl[i].z_ov, tbl[i].z_no, i);
        end

        // Mealy timing: park in S3, toggle xin 0 -> 1 before the edge
        do_reset();
        step(1'b1, 1'b0, 1'b0, 200);
        step(1'b0, 1'b0, 1'b0, 201);
        step(1'b1, 1'b0, 1'b0, 202);
        @(negedge clk);
        xin = 1'b0;
        #1;
        check("mealy_lo_ov", 0, 32'(zout_ov), 32'd0);
        check("mealy_lo_no", 0, 32'(zout_no), 32'd0);
        #1;
        xin = 1'b1;
        #1;
        check("mealy_hi_ov", 0, 32'(zout_ov), 32'd1);
        check("mealy_hi_no", 0, 32'(zout_no), 32'd1);

        // Async reset mid-pattern: still in S3 with xin=1, pull rst low between edges
        #1;
        rst = 1'b0;
        #1;
        check("async_z_ov", 0, 32'(zout_ov), 32'd0);
        check("async_z_no", 0, 32'(zout_no), 32'd0);
        exp_cnt_ov = 0;
        exp_cnt_no = 0;
        check_counts(300);
        #1;
        rst = 1'b1;
        xin = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 301);
        // state restarted from S0: a full 1011 is needed again
        step(1'b0, 1'b0, 1'b0, 302);
        step(1'b1, 1'b0, 1'b0, 303);
        step(1'b1, 1'b1, 1'b1, 304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
